// File: rtl/shift_pkg.sv
// Shared shifter definitions: function codes, widths, buffer occupancy
// states and the result-buffer entry layout.
package shift_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 2;

   typedef enum logic [1:0] {
      SHL = 2'd0,
      SHR = 2'd1,
      ROL = 2'd2,
      ROR = 2'd3
   } shift_fn_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              c;
      logic              z;
      logic [ADDR_W-1:0] addr;
      logic              upd;
   } entry_t;

   // The zero flag is always derived locally from the data byte.
   function automatic entry_t make_entry(input logic [DATA_W-1:0] data,
                                         input logic              c,
                                         input logic [ADDR_W-1:0] addr,
                                         input logic              upd);
      entry_t e;
      e.data = data;
      e.c    = c;
      e.z    = (data == '0);
      e.addr = addr;
      e.upd  = upd;
      return e;
   endfunction

endpackage

// File: rtl/shift_result_buffer.sv
// Two-entry in-order buffer between the shifter and register-file writeback;
// owns the architectural C/Z flags, which are committed as entries retire.
module shift_result_buffer
   import shift_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_c,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic              in_upd,
   input  logic              flush,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [DATA_W-1:0] wb_data,
   output logic [ADDR_W-1:0] wb_addr,
   output logic              c_flag,
   output logic              z_flag,
   output logic [1:0]        count
);

   occ_t   state;
   occ_t   next_state;
   entry_t mem [DEPTH];
   entry_t head;
   logic   wr_ptr;
   logic   rd_ptr;
   logic   enq;
   logic   deq;

   assign enq  = in_valid && in_ready;
   assign deq  = wb_valid && wb_ready;
   assign head = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= next_state;
      end
   end

   // NOTE: next_state gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      if (flush) begin
         next_state = EMPTY;
      end else begin
         case (state)
            EMPTY: if (enq) next_state = ONE;
            ONE: begin
               if (enq && !deq)      next_state = FULL;
               else if (deq && !enq) next_state = EMPTY;
            end
            FULL:    if (deq) next_state = ONE;
            default: next_state = EMPTY;
         endcase
      end
   end

   // Handshake and occupancy outputs depend on the state register alone.
   always_comb begin
      in_ready = 1'b1;
      wb_valid = 1'b0;
      count    = 2'd0;
      case (state)
         EMPTY: begin
            in_ready = 1'b1;
            wb_valid = 1'b0;
            count    = 2'd0;
         end
         ONE: begin
            in_ready = 1'b1;
            wb_valid = 1'b1;
            count    = 2'd1;
         end
         FULL: begin
            in_ready = 1'b0;
            wb_valid = 1'b1;
            count    = 2'd2;
         end
         default: begin
            in_ready = 1'b1;
            wb_valid = 1'b0;
            count    = 2'd0;
         end
      endcase
   end

   // Pointers and flags; flush drops entries without committing the head.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         c_flag <= 1'b0;
         z_flag <= 1'b0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (enq) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (deq) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (head.upd) begin
               c_flag <= head.c;
               z_flag <= head.z;
            end
         end
      end
   end

   // NOTE: entry storage is not reset; its contents are only observed while
   // wb_valid is high, which requires a prior enqueue.
   always_ff @(posedge clk) begin
      if (enq) begin
         mem[wr_ptr] <= make_entry(in_data, in_c, in_addr, in_upd);
      end
   end

   // The write pointer never aliases the head while it is presented, so
   // wb_data/wb_addr stay stable under backpressure.
   assign wb_data = head.data;
   assign wb_addr = head.addr;

endmodule

// File: tb/tb_shift_result_buffer.sv
// Directed and randomized checks of shift_result_buffer against a queue-based
// reference model of the buffer and flag commit rules.
module tb_shift_result_buffer;
   import shift_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_c;
   logic [ADDR_W-1:0] in_addr;
   logic              in_upd;
   logic              flush;
   logic              wb_valid;
   logic              wb_ready;
   logic [DATA_W-1:0] wb_data;
   logic [ADDR_W-1:0] wb_addr;
   logic              c_flag;
   logic              z_flag;
   logic [1:0]        count;

   int     tests = 0;
   int     fails = 0;
   entry_t q[$];
   logic   m_c;
   logic   m_z;

   always #5 clk = ~clk;

   shift_result_buffer dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_c     (in_c),
      .in_addr  (in_addr),
      .in_upd   (in_upd),
      .flush    (flush),
      .wb_valid (wb_valid),
      .wb_ready (wb_ready),
      .wb_data  (wb_data),
      .wb_addr  (wb_addr),
      .c_flag   (c_flag),
      .z_flag   (z_flag),
      .count    (count)
   );

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic check_model();
      check("count", 32'(count), 32'(q.size()));
      check("in_ready", 32'(in_ready), 32'(q.size() < 2));
      check("wb_valid", 32'(wb_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
         check("wb_data", 32'(wb_data), 32'(q[0].data));
         check("wb_addr", 32'(wb_addr), 32'(q[0].addr));
      end
      check("c_flag", 32'(c_flag), 32'(m_c));
      check("z_flag", 32'(z_flag), 32'(m_z));
   endtask

   // One clock: check outputs against the model, drive inputs, advance model.
   task automatic step(input logic r, input logic f, input logic v,
                       input logic [7:0] d, input logic c, input logic [2:0] a,
                       input logic u, input logic wr);
      logic   m_enq;
      logic   m_deq;
      entry_t h;
      @(negedge clk);
      check_model();
      rst      = r;
      flush    = f;
      in_valid = v;
      in_data  = d;
      in_c     = c;
      in_addr  = a;
      in_upd   = u;
      wb_ready = wr;
      @(posedge clk);
      m_enq = v && (q.size() < 2);
      m_deq = wr && (q.size() > 0);
      if (r) begin
         q.delete();
         m_c = 1'b0;
         m_z = 1'b0;
      end else if (f) begin
         q.delete();
      end else begin
         if (m_deq) begin
            h = q.pop_front();
            if (h.upd) begin
               m_c = h.c;
               m_z = h.z;
            end
         end
         if (m_enq) begin
            h.data = d;
            h.c    = c;
            h.z    = (d == 8'h00);
            h.addr = a;
            h.upd  = u;
            q.push_back(h);
         end
      end
      #1;
   endtask

   task automatic enq(input logic [7:0] d, input logic c, input logic [2:0] a,
                      input logic u, input logic wr);
      step(1'b0, 1'b0, 1'b1, d, c, a, u, wr);
   endtask

   task automatic idle(input logic wr);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, wr);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_c = 1'b0;
      in_addr = '0; in_upd = 1'b0; wb_ready = 1'b0;
      m_c = 1'b0; m_z = 1'b0;
      @(posedge clk);
      #1;
      idle(1'b0);
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset wb_valid", 32'(wb_valid), 32'd0);
      check("reset count", 32'(count), 32'd0);

      // Basic transfer
      enq(8'h80, 1'b1, 3'd5, 1'b1, 1'b1);
      check("xfer wb_valid", 32'(wb_valid), 32'd1);
      check("xfer wb_data", 32'(wb_data), 32'h80);
      check("xfer wb_addr", 32'(wb_addr), 32'd5);
      idle(1'b1);
      check("xfer c_flag", 32'(c_flag), 32'd1);
      check("xfer z_flag", 32'(z_flag), 32'd0);

      // Zero detect, then an entry that leaves the flags alone
      enq(8'h00, 1'b0, 3'd2, 1'b1, 1'b1);
      idle(1'b1);
      check("zero z_flag", 32'(z_flag), 32'd1);
      check("zero c_flag", 32'(c_flag), 32'd0);
      enq(8'h01, 1'b1, 3'd3, 1'b0, 1'b1);
      idle(1'b1);
      check("noupd z_flag", 32'(z_flag), 32'd1);
      check("noupd c_flag", 32'(c_flag), 32'd0);

      // Fill and backpressure
      enq(8'h11, 1'b0, 3'd1, 1'b1, 1'b0);
      enq(8'h22, 1'b0, 3'd2, 1'b1, 1'b0);
      check("full count", 32'(count), 32'd2);
      check("full in_ready", 32'(in_ready), 32'd0);
      enq(8'h33, 1'b0, 3'd3, 1'b1, 1'b0);
      check("reject count", 32'(count), 32'd2);
      check("stall wb_data", 32'(wb_data), 32'h11);
      idle(1'b1);
      check("order 2nd", 32'(wb_data), 32'h22);
      idle(1'b1);
      check("drained", 32'(count), 32'd0);

      // Simultaneous enqueue and dequeue in ONE
      enq(8'h5A, 1'b0, 3'd4, 1'b1, 1'b0);
      enq(8'hA5, 1'b0, 3'd6, 1'b1, 1'b1);
      check("simul count", 32'(count), 32'd1);
      check("simul wb_data", 32'(wb_data), 32'hA5);
      idle(1'b1);

      // Flush in FULL with a committing head: flags untouched
      enq(8'h40, 1'b1, 3'd0, 1'b1, 1'b0);
      enq(8'h41, 1'b1, 3'd1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1);
      check("flush count", 32'(count), 32'd0);
      check("flush c_flag", 32'(c_flag), 32'd0);

      // Reset mid-operation after flags are set
      enq(8'h00, 1'b1, 3'd7, 1'b1, 1'b1);
      idle(1'b1);
      enq(8'h70, 1'b1, 3'd1, 1'b1, 1'b0);
      enq(8'h71, 1'b1, 3'd2, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1);
      check("rst count", 32'(count), 32'd0);
      check("rst wb_valid", 32'(wb_valid), 32'd0);
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst c_flag", 32'(c_flag), 32'd0);
      check("rst z_flag", 32'(z_flag), 32'd0);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 79) == 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 2) != 0,
              ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
              1'($urandom), 3'($urandom), 1'($urandom),
              $urandom_range(0, 2) != 0);
      end
      idle(1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/shift_result_buffer.md
SHIFT_RESULT_BUFFER -- requirements
Module: shift_result_buffer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: the shifter result on in_data/in_c/in_addr/in_upd is valid this cycle.
REQ-004 SHALL have port in_ready, output, 1 bit: the buffer accepts an entry this cycle.
REQ-005 SHALL have port in_data, input, 8 bits: shifter result byte.
REQ-006 SHALL have port in_c, input, 1 bit: shifter carry-out.
REQ-007 SHALL have port in_addr, input, 3 bits: destination register index.
REQ-008 SHALL have port in_upd, input, 1 bit: the entry updates the C/Z flags at commit.
REQ-009 SHALL have port flush, input, 1 bit: discard all buffered entries.
REQ-010 SHALL have port wb_valid, output, 1 bit: the head entry is presented for writeback.
REQ-011 SHALL have port wb_ready, input, 1 bit: the register file accepts the head entry.
REQ-012 SHALL have port wb_data, output, 8 bits: head entry data.
REQ-013 SHALL have port wb_addr, output, 3 bits: head entry destination.
REQ-014 SHALL have port c_flag, output, 1 bit: architectural carry flag.
REQ-015 SHALL have port z_flag, output, 1 bit: architectural zero flag.
REQ-016 SHALL have port count, output, 2 bits: occupancy, 0 to 2.

Function
REQ-017 SHALL implement a 2-entry in-order buffer, each entry being {data[7:0], c, z, addr[2:0], upd}.
REQ-018 SHALL compute entry z at enqueue as (in_data == 8'h00) and ignore any upstream zero indication.
REQ-019 SHALL occupy one of the states EMPTY, ONE or FULL, with count equal to 0, 1 or 2 respectively.
REQ-020 SHALL drive in_ready = 1 in EMPTY and ONE, and 0 in FULL; there is no same-cycle pass-through when FULL.
REQ-021 SHALL enqueue only when in_valid && in_ready, and dequeue only when wb_valid && wb_ready.
REQ-022 SHALL drive wb_valid = (state != EMPTY), with wb_data and wb_addr taken from the head entry, all registered.
REQ-023 SHALL have 1-cycle latency: an entry accepted at edge N is presented no earlier than cycle N+1; there is no combinational bypass from in_* to wb_*.
REQ-024 SHALL apply these transitions:
- EMPTY with enqueue goes to ONE.
- ONE with enqueue only goes to FULL.
- ONE with dequeue only goes to EMPTY.
- ONE with both stays in ONE, and the new entry becomes the head next cycle.
- FULL with dequeue goes to ONE.
- Otherwise the state holds.
REQ-025 SHALL preserve order and implement read/write pointers that wrap modulo 2.
REQ-026 SHALL hold wb_data and wb_addr stable while wb_valid && !wb_ready.
REQ-027 SHALL load c_flag <= head.c and z_flag <= head.z on dequeue when head.upd = 1, and leave both flags unchanged when head.upd = 0.
REQ-028 SHALL, on flush, set the state to EMPTY next cycle, with flush taking priority over a simultaneous enqueue and dequeue.
REQ-029 SHALL NOT update the flags on a flush cycle, even if a dequeue handshake coincides with it.
REQ-030 SHALL keep in_ready combinational from state only, independent of wb_ready.

Reset
REQ-031 SHALL, on rst, set the state to EMPTY, count 0, both pointers 0, c_flag 0 and z_flag 0.
REQ-032 SHALL give rst priority over flush, enqueue and dequeue.
REQ-033 SHALL, on rst mid-operation, discard buffered entries without committing any flags.
REQ-034 SHALL hold in_ready = 1 and wb_valid = 0 in the cycle after reset.
REQ-035 SHALL NOT require entry storage to be reset; wb_data and wb_addr are don't-care while wb_valid = 0.

Structure
REQ-036 SHALL take from shared package shift_pkg:
- shifter function codes SHL=0, SHR=1, ROL=2, ROR=3;
- DATA_W=8 and ADDR_W=3;
- the occupancy state enum {EMPTY, ONE, FULL};
- the entry struct type.
REQ-037 SHALL be implemented as a single module with no sub-modules, and the flag register SHALL reside inside it.

Verification
REQ-038 SHALL cover basic transfer: enqueue data=8'h80, c=1, addr=5, upd=1 with wb_ready=1 -> wb_valid next cycle, wb_data=8'h80, wb_addr=5; after the handshake c_flag=1, z_flag=0.
REQ-039 SHALL cover zero detect: enqueue data=8'h00, c=0, upd=1 -> after commit z_flag=1, c_flag=0; then an upd=0 entry with data=8'h01 -> flags unchanged.
REQ-040 SHALL cover fill and backpressure: wb_ready=0, enqueue 8'h11 then 8'h22 -> count=2, in_ready=0, a third offer of 8'h33 is not accepted; then wb_ready=1 -> 8'h11, 8'h22 emitted in order.
REQ-041 SHALL cover simultaneous events: in ONE, enqueue 8'hA5 with dequeue in the same cycle -> count stays 1 and wb_data=8'hA5 next cycle.
REQ-042 SHALL cover flush: FULL with head c=1, upd=1, flush asserted with wb_ready=1 -> count=0 next cycle, c_flag unchanged at 0.
REQ-043 SHALL cover reset mid-operation: rst asserted in FULL -> count=0, wb_valid=0, in_ready=1, c_flag=0, z_flag=0 next cycle.
